// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out transmitter.
// The optional PISO_BACK2BACK_EN build macro is consumed by piso_shift_tx.
package piso_pkg;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;
endpackage

// File: rtl/piso_shift_tx.sv
// LSB-first parallel-in/serial-out transmitter with a valid/ready load port.
// Define PISO_BACK2BACK_EN to allow a reload in the last bit cycle (gapless frames).
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              serial_data,
    output logic              data_ena,
    output logic              frame_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;
    logic              accept;

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST);

`ifdef PISO_BACK2BACK_EN
    assign load_ready = (state == IDLE) || last_bit;
`else
    assign load_ready = (state == IDLE);
`endif

    assign accept      = load_valid && load_ready;
    assign data_ena    = (state == SHIFT);
    assign serial_data = (state == SHIFT) && shreg[0];

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_bit;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= load_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // Counter is cleared explicitly so non-power-of-two widths wrap correctly
                        bit_cnt <= '0;
                        shreg   <= shreg >> 1;
`ifdef PISO_BACK2BACK_EN
                        if (accept) begin
                            shreg <= load_data;
                            state <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= DONE;
`endif
                    end else begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx with a behavioural SIPO receiver on the serial side.
// Builds with or without PISO_BACK2BACK_EN.
module tb_piso_shift_tx;
`ifdef PISO_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       lv, rdy, sd, de, fd;
    logic [7:0] ld;
    logic       lv2, rdy2, sd2, de2, fd2;
    logic [1:0] ld2;
    logic [7:0] rx;

    int vecs = 0;
    int errs = 0;

    always #5 clk_50 = ~clk_50;

    piso_shift_tx #(.DATA_W(8)) u_dut (
        .clk_50(clk_50), .reset(reset), .load_valid(lv), .load_data(ld),
        .load_ready(rdy), .serial_data(sd), .data_ena(de), .frame_done(fd)
    );

    piso_shift_tx #(.DATA_W(2)) u_dut2 (
        .clk_50(clk_50), .reset(reset), .load_valid(lv2), .load_data(ld2),
        .load_ready(rdy2), .serial_data(sd2), .data_ena(de2), .frame_done(fd2)
    );

    // Reference receiver: captures one bit per enabled edge, LSB first
    always_ff @(posedge clk_50) begin
        if (de) rx <= {sd, rx[7:1]};
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept w at the next edge, then verify every bit, the frame_done pulse and the receiver word
    task automatic send_word(input logic [7:0] w, input string tag);
        ld = w;
        lv = 1'b1;
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
        tick();
        lv = 1'b0;
        ld = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), 32'(sd), 32'(w[k]));
            chk($sformatf("%s_ena%0d", tag, k), 32'(de), 32'd1);
            chk($sformatf("%s_fd%0d", tag, k), 32'(fd), 32'd0);
            chk($sformatf("%s_rdy%0d", tag, k), 32'(rdy), 32'(B2B && (k == 7)));
            tick();
        end
        chk({tag, "_done"}, 32'(fd), 32'd1);
        chk({tag, "_done_ena"}, 32'(de), 32'd0);
        chk({tag, "_done_rdy"}, 32'(rdy), 32'(B2B));
        chk({tag, "_rx"}, 32'(rx), 32'(w));
        tick();
        chk({tag, "_fd_clr"}, 32'(fd), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        lv = 1'b0; ld = 8'h00;
        lv2 = 1'b0; ld2 = 2'b00;
        #2;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_fd", 32'(fd), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic frame and loopback words
        send_word(8'hA5, "a5");
        send_word(8'h3C, "w3c");
        send_word(8'h00, "w00");
        send_word(8'hFF, "wff");
        send_word(8'h80, "w80");
        send_word(8'h01, "w01");

        // New data offered during SHIFT must not disturb the in-flight word
        ld = 8'hC3;
        lv = 1'b1;
        tick();
        ld = 8'h99;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("hold_bit%0d", k), 32'(sd), 32'((8'hC3 >> k) & 8'h01));
            chk($sformatf("hold_rdy%0d", k), 32'(rdy), 32'd0);
            tick();
        end
        lv = 1'b0;
        chk("hold_bit7", 32'(sd), 32'd1);
        tick();
        chk("hold_rx", 32'(rx), 32'hC3);
`ifndef PISO_BACK2BACK_EN
        // DONE cycle still refuses; earliest accept is E0+DATA_W+2
        lv = 1'b1;
        chk("hold_done_rdy", 32'(rdy), 32'd0);
        tick();
        chk("hold_no_accept", 32'(de), 32'd0);
        lv = 1'b0;
`endif
        tick();
        send_word(8'h99, "w99");

        // Reset during bit 3 abandons the frame
        ld = 8'hF0;
        lv = 1'b1;
        tick();
        lv = 1'b0;
        tick(); tick(); tick();
        chk("mid_ena_pre", 32'(de), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_sd", 32'(sd), 32'd0);
        chk("mid_rst_de", 32'(de), 32'd0);
        chk("mid_rst_fd", 32'(fd), 32'd0);
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid_nofd%0d", k), 32'(fd), 32'd0);
            chk($sformatf("mid_idle_de%0d", k), 32'(de), 32'd0);
            tick();
        end
        send_word(8'h5A, "w5a");

`ifdef PISO_BACK2BACK_EN
        // Gapless stream of three words
        begin
            logic [7:0] words [3];
            words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
            ld = words[0];
            lv = 1'b1;
            tick();
            lv = 1'b0;
            for (int w = 0; w < 3; w++) begin
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("st%0d_ena%0d", w, k), 32'(de), 32'd1);
                    chk($sformatf("st%0d_bit%0d", w, k), 32'(sd), 32'((words[w] >> k) & 8'h01));
                    chk($sformatf("st%0d_fd%0d", w, k), 32'(fd), 32'((k == 0) && (w > 0)));
                    if (k == 0 && w > 0)
                        chk($sformatf("st%0d_rx", w), 32'(rx), 32'(words[w-1]));
                    chk($sformatf("st%0d_rdy%0d", w, k), 32'(rdy), 32'(k == 7));
                    if (k == 7 && w < 2) begin
                        ld = words[w+1];
                        lv = 1'b1;
                    end
                    tick();
                    lv = 1'b0;
                end
            end
            chk("st_end_fd", 32'(fd), 32'd1);
            chk("st_end_de", 32'(de), 32'd0);
            chk("st_end_rx", 32'(rx), 32'h33);
            tick();
            chk("st_end_fd_clr", 32'(fd), 32'd0);
        end
`endif

        // Minimum width instance
        ld2 = 2'b10;
        lv2 = 1'b1;
        chk("w2_rdy", 32'(rdy2), 32'd1);
        tick();
        lv2 = 1'b0;
        chk("w2_bit0", 32'(sd2), 32'd0);
        chk("w2_ena0", 32'(de2), 32'd1);
        tick();
        chk("w2_bit1", 32'(sd2), 32'd1);
        chk("w2_ena1", 32'(de2), 32'd1);
        chk("w2_fd_early", 32'(fd2), 32'd0);
        tick();
        chk("w2_fd", 32'(fd2), 32'd1);
        chk("w2_de_off", 32'(de2), 32'd0);
        tick();
        chk("w2_fd_clr", 32'(fd2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
